// File: rtl/ntt_intt_engine_if.sv
// ntt_intt_engine_if: vector handshake, twiddle lookup and result bus for the NTT/INTT engine
interface ntt_intt_engine_if #(parameter int N = 17, parameter int D = 8);
  localparam int SW = ($clog2(D) < 1) ? 1 : $clog2(D);
  logic in_valid;
  logic in_ready;
  logic mode;
  logic [D*N-1:0] a;
  logic [SW-1:0] tw_stage;
  logic tw_mode;
  logic [(D/2)*N-1:0] tw;
  logic out_valid;
  logic out_ready;
  logic [D*N-1:0] b;
  modport master(output in_valid, mode, a, tw, out_ready, input in_ready, tw_stage, tw_mode, out_valid, b);
  modport slave(input in_valid, mode, a, tw, out_ready, output in_ready, tw_stage, tw_mode, out_valid, b);
endinterface

// File: rtl/ntt_intt_engine.sv
// ntt_intt_engine: iterative D-point NTT (Cooley-Tukey) / INTT (Gentleman-Sande), one stage per cycle
module ntt_intt_engine #(
  parameter int N = 17,
  parameter int D = 8,
  parameter int Q = 65537,
  parameter int NINV = 57345
) (
  input logic clk,
  input logic rst,
  ntt_intt_engine_if.slave io
);
  localparam int L = $clog2(D);
  typedef enum logic [1:0] {IDLE, RUN, SCALE, DONE} state_t;
  state_t state, nstate;
  logic [L-1:0] s, h, i, j, kk;
  logic md;
  logic [N-1:0] t;
  logic [N-1:0] x [D];
  logic [N-1:0] nx [D];
  function automatic logic [N-1:0] mulm(input logic [N-1:0] p, input logic [N-1:0] r);
    logic [2*N-1:0] m;
    m = (2*N)'(p) * (2*N)'(r);
    return N'(m % (2*N)'(Q));
  endfunction
  function automatic logic [N-1:0] addm(input logic [N-1:0] p, input logic [N-1:0] r);
    logic [N:0] u;
    u = {1'b0, p} + {1'b0, r};
    return N'((u >= (N+1)'(Q)) ? u - (N+1)'(Q) : u);
  endfunction
  function automatic logic [N-1:0] subm(input logic [N-1:0] p, input logic [N-1:0] r);
    return (p >= r) ? p - r : N'({1'b0, p} + (N+1)'(Q) - {1'b0, r});
  endfunction
  // pair k has lower index k with the block offset inserted above bit log2(h)
  always_comb begin
    nx = x;
    h = md ? L'(1) << s : L'(D/2) >> s;
    {i, j, kk} = '0;
    t = '0;
    for (int k = 0; k < D/2; k++) begin
      kk = L'(k);
      i = kk + (kk & ~(h - L'(1)));
      j = i + h;
      if (md) begin
        nx[i] = addm(x[i], x[j]);
        nx[j] = mulm(subm(x[i], x[j]), io.tw[N*k +: N]);
      end else begin
        t = mulm(io.tw[N*k +: N], x[j]);
        nx[i] = addm(x[i], t);
        nx[j] = subm(x[i], t);
      end
    end
  end
  always_comb begin
    nstate = state;
    case (state)
      IDLE: nstate = io.in_valid ? RUN : IDLE;
      RUN: nstate = (s == L'(L-1)) ? (md ? SCALE : DONE) : RUN;
      SCALE: nstate = DONE;
      DONE: nstate = io.out_ready ? IDLE : DONE;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s <= '0;
      md <= 1'b0;
      x <= '{default: '0};
    end else begin
      state <= nstate;
      if (state == IDLE && io.in_valid) begin
        md <= io.mode;
        s <= '0;
        for (int k = 0; k < D; k++) x[k] <= N'(io.a[N*k +: N] % N'(Q));
      end else if (state == RUN) begin
        x <= nx;
        s <= (s == L'(L-1)) ? '0 : s + L'(1);
      end else if (state == SCALE) begin
        for (int k = 0; k < D; k++) x[k] <= mulm(x[k], N'(NINV));
      end
    end
  end
  assign io.in_ready = state == IDLE;
  assign io.out_valid = state == DONE;
  assign io.tw_stage = s;
  assign io.tw_mode = md;
  for (genvar g = 0; g < D; g++) begin : g_b
    assign io.b[N*g +: N] = x[g];
  end
endmodule
